// File: rtl/ysyx_22040750_npc_pkg.sv
// ysyx_22040750_npc_pkg: shared defaults and redirect-priority encoding for the next-PC generator.
package ysyx_22040750_npc_pkg;
    localparam int          XLEN_DEF   = 32;
    localparam logic [63:0] RST_PC_DEF = 64'h8000_0000;
    typedef enum logic [1:0] {
        REDIR_NONE = 2'd0,
        REDIR_JMP  = 2'd1,
        REDIR_TRAP = 2'd2
    } redir_kind_e;
endpackage

// File: rtl/ysyx_22040750_npc_redir_arb.sv
// ysyx_22040750_npc_redir_arb: picks the effective redirect among live/held traps and jumps.
module ysyx_22040750_npc_redir_arb
    import ysyx_22040750_npc_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic             live_trap,
    input  logic [XLEN-1:0]  live_trap_pc,
    input  logic             live_jmp,
    input  logic [XLEN-1:0]  live_jmp_pc,
    input  redir_kind_e      held_kind,
    input  logic [XLEN-1:0]  held_pc,
    output redir_kind_e      kind,
    output logic [XLEN-1:0]  target
);
    logic held_trap;
    assign held_trap = held_kind == REDIR_TRAP;
    // live trap > held trap > live jump > held jump
    always_comb begin
        kind   = live_trap ? REDIR_TRAP : held_trap ? REDIR_TRAP : live_jmp ? REDIR_JMP : held_kind;
        target = live_trap ? live_trap_pc : held_trap ? held_pc : live_jmp ? live_jmp_pc : held_pc;
    end
endmodule

// File: rtl/ysyx_22040750_npc_gen.sv
// ysyx_22040750_npc_gen: fetch PC register with valid/ready handshake and held jump/trap redirects.
module ysyx_22040750_npc_gen
    import ysyx_22040750_npc_pkg::*;
#(
    parameter int              XLEN       = XLEN_DEF,
    parameter logic [XLEN-1:0] RST_PC     = RST_PC_DEF[XLEN-1:0],
    parameter int              ILEN_BYTES = 4
) (
    input  logic             I_clk,
    input  logic             I_rst,
    output logic [XLEN-1:0]  O_pc,
    output logic             O_pc_valid,
    input  logic             I_pc_ready,
    input  logic             I_jmp_valid,
    input  logic             I_jmp_sel_rs1,
    input  logic [XLEN-1:0]  I_jmp_pc,
    input  logic [XLEN-1:0]  I_rs1_data,
    input  logic [XLEN-1:0]  I_imm,
    input  logic             I_trap_valid,
    input  logic [XLEN-1:0]  I_trap_pc,
    output logic             O_redir_pending,
    output logic             O_redir_pending_trap
);
    logic [XLEN-1:0] pc_q;
    logic            valid_q;
    redir_kind_e     held_kind_q;
    logic [XLEN-1:0] held_pc_q;
    logic [XLEN-1:0] jmp_tgt;
    logic [XLEN-1:0] rs1_sum;
    redir_kind_e     eff_kind;
    logic [XLEN-1:0] eff_pc;
    logic            hs;

    assign rs1_sum = I_rs1_data + I_imm;
    assign jmp_tgt = I_jmp_sel_rs1 ? {rs1_sum[XLEN-1:1], 1'b0} : I_jmp_pc + I_imm;
    assign hs      = valid_q && I_pc_ready;

    ysyx_22040750_npc_redir_arb #(.XLEN(XLEN)) u_arb (
        .live_trap    (I_trap_valid),
        .live_trap_pc (I_trap_pc),
        .live_jmp     (I_jmp_valid),
        .live_jmp_pc  (jmp_tgt),
        .held_kind    (held_kind_q),
        .held_pc      (held_pc_q),
        .kind         (eff_kind),
        .target       (eff_pc)
    );

    // The hold register always tracks the effective redirect until a handshake consumes it.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            pc_q        <= RST_PC;
            valid_q     <= 1'b0;
            held_kind_q <= REDIR_NONE;
            held_pc_q   <= '0;
        end else begin
            valid_q     <= 1'b1;
            pc_q        <= hs ? ((eff_kind != REDIR_NONE) ? eff_pc : pc_q + XLEN'(ILEN_BYTES)) : pc_q;
            held_kind_q <= hs ? REDIR_NONE : eff_kind;
            held_pc_q   <= hs ? '0 : eff_pc;
        end
    end

    assign O_pc                 = pc_q;
    assign O_pc_valid           = valid_q;
    assign O_redir_pending      = held_kind_q != REDIR_NONE;
    assign O_redir_pending_trap = held_kind_q == REDIR_TRAP;
endmodule

// File: tb/tb_ysyx_22040750_npc_gen.sv
// tb_ysyx_22040750_npc_gen: directed vectors for the next-PC generator with hand-computed expectations.
module tb_ysyx_22040750_npc_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic        jmp_valid;
    logic        jmp_sel_rs1;
    logic [31:0] jmp_pc;
    logic [31:0] rs1_data;
    logic [31:0] imm;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic        pend;
    logic        pend_trap;
    int          n_pass = 0;
    int          n_chk  = 0;

    always #5 clk = ~clk;

    ysyx_22040750_npc_gen dut (
        .I_clk                (clk),
        .I_rst                (rst),
        .O_pc                 (pc),
        .O_pc_valid           (pc_valid),
        .I_pc_ready           (pc_ready),
        .I_jmp_valid          (jmp_valid),
        .I_jmp_sel_rs1        (jmp_sel_rs1),
        .I_jmp_pc             (jmp_pc),
        .I_rs1_data           (rs1_data),
        .I_imm                (imm),
        .I_trap_valid         (trap_valid),
        .I_trap_pc            (trap_pc),
        .O_redir_pending      (pend),
        .O_redir_pending_trap (pend_trap)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic jmp(input logic [31:0] p, input logic [31:0] i);
        jmp_valid = 1'b1; jmp_sel_rs1 = 1'b0; jmp_pc = p; imm = i;
    endtask

    initial begin
        rst = 1'b1; pc_ready = 1'b1; jmp_valid = 1'b0; jmp_sel_rs1 = 1'b0;
        jmp_pc = '0; rs1_data = '0; imm = '0; trap_valid = 1'b0; trap_pc = '0;
        step(); step();
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_valid", {31'b0, pc_valid}, 32'd0);
        chk("rst_pend", {31'b0, pend}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_valid", {31'b0, pc_valid}, 32'd0);
        step();
        chk("valid_up", {31'b0, pc_valid}, 32'd1);
        chk("pc0", pc, 32'h8000_0000);
        step(); chk("pc1", pc, 32'h8000_0004);
        step(); chk("pc2", pc, 32'h8000_0008);
        step(); step(); chk("pc4", pc, 32'h8000_0010);
        // zero-bubble jump at handshake
        jmp(32'h8000_000C, 32'h20);
        step(); jmp_valid = 1'b0;
        chk("jmp_pc", pc, 32'h8000_002C);
        chk("jmp_nopend", {31'b0, pend}, 32'd0);
        // jalr while stalled
        pc_ready = 1'b0; jmp_valid = 1'b1; jmp_sel_rs1 = 1'b1; rs1_data = 32'h8000_1001; imm = 32'h4;
        step(); jmp_valid = 1'b0; jmp_sel_rs1 = 1'b0;
        chk("stall_pc", pc, 32'h8000_002C);
        chk("stall_pend", {31'b0, pend}, 32'd1);
        chk("stall_ptrap", {31'b0, pend_trap}, 32'd0);
        step(); step();
        chk("stall_pc3", pc, 32'h8000_002C);
        pc_ready = 1'b1;
        step();
        chk("jalr_pc", pc, 32'h8000_1004);
        chk("jalr_pend", {31'b0, pend}, 32'd0);
        step(); chk("jalr_seq", pc, 32'h8000_1008);
        // held jump, then trap, then another jump
        pc_ready = 1'b0; jmp(32'h8000_0100, 32'h0);
        step(); jmp_valid = 1'b0;
        chk("hj_pend", {31'b0, pend}, 32'd1);
        chk("hj_ptrap", {31'b0, pend_trap}, 32'd0);
        trap_valid = 1'b1; trap_pc = 32'h8000_0200;
        step(); trap_valid = 1'b0;
        chk("ht_ptrap", {31'b0, pend_trap}, 32'd1);
        jmp(32'h8000_0300, 32'h0);
        step(); jmp_valid = 1'b0;
        chk("ht_keep", {31'b0, pend_trap}, 32'd1);
        chk("ht_pc_hold", pc, 32'h8000_1008);
        pc_ready = 1'b1;
        step();
        chk("ht_pc", pc, 32'h8000_0200);
        chk("ht_clear", {31'b0, pend}, 32'd0);
        // simultaneous trap and jump
        trap_valid = 1'b1; trap_pc = 32'h8000_0400; jmp(32'h8000_0500, 32'h0);
        step(); trap_valid = 1'b0; jmp_valid = 1'b0;
        chk("tj_pc", pc, 32'h8000_0400);
        chk("tj_pend", {31'b0, pend}, 32'd0);
        // wraparound
        jmp(32'hFFFF_FFF0, 32'h0C);
        step(); jmp_valid = 1'b0;
        chk("wrap_pre", pc, 32'hFFFF_FFFC);
        step(); chk("wrap", pc, 32'h0000_0000);
        step(); chk("wrap_seq", pc, 32'h0000_0004);
        // reset with a pending redirect
        pc_ready = 1'b0; jmp(32'h8000_0700, 32'h0);
        step(); jmp_valid = 1'b0;
        chk("pre_rst_pend", {31'b0, pend}, 32'd1);
        rst = 1'b1; jmp(32'h8000_0900, 32'h0); pc_ready = 1'b1;
        step();
        chk("rst2_pc", pc, 32'h8000_0000);
        chk("rst2_pend", {31'b0, pend}, 32'd0);
        chk("rst2_valid", {31'b0, pc_valid}, 32'd0);
        // redirect arriving while not yet valid is held
        rst = 1'b0; jmp(32'h8000_0800, 32'h0);
        step(); jmp_valid = 1'b0;
        chk("inv_pc", pc, 32'h8000_0000);
        chk("inv_pend", {31'b0, pend}, 32'd1);
        step();
        chk("inv_apply", pc, 32'h8000_0800);
        chk("inv_clear", {31'b0, pend}, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
